// File: rtl/sub_bytes_engine.sv
// sub_bytes_engine: AES SubBytes over a DATA_W state, LANES bytes per clock, valid/ready on both sides.
// Define INV_SBOX_EN to add the inverse S-box, selected per block by inv_mode.
module sub_bytes_engine #(
  parameter int LANES  = 4,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              inv_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);
  localparam int NBYTES = DATA_W / 8;
  localparam int GROUPS = NBYTES / LANES;
  localparam int CW     = GROUPS > 1 ? $clog2(GROUPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(GROUPS - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16) ||
      DATA_W <= 0 || DATA_W % (8 * LANES) != 0) begin : g_bad_cfg
    $fatal(1, "sub_bytes_engine: illegal LANES=%0d / DATA_W=%0d", LANES, DATA_W);
  end

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  // S-box computed as GF(2^8) inverse plus affine map rather than stored tables
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, s;
    r = 8'h01;
    s = a;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
  endfunction

`ifdef INV_SBOX_EN
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv(rl(a, 1) ^ rl(a, 3) ^ rl(a, 6) ^ 8'h05);
  endfunction

  logic mode_q, mode_d;
`else
  logic unused_inv_mode;
  assign unused_inv_mode = inv_mode;
`endif

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d, out_q, out_d, sub;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      out_q   <= '0;
`ifdef INV_SBOX_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      out_q   <= out_d;
`ifdef INV_SBOX_EN
      mode_q  <= mode_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    out_d   = out_q;
    sub     = data_q;
`ifdef INV_SBOX_EN
    mode_d  = mode_q;
`endif
    for (int l = 0; l < LANES; l++) begin
`ifdef INV_SBOX_EN
      sub[(int'(cnt_q) * LANES + l) * 8 +: 8] = mode_q ?
          inv_sbox(data_q[(int'(cnt_q) * LANES + l) * 8 +: 8]) :
          fwd_sbox(data_q[(int'(cnt_q) * LANES + l) * 8 +: 8]);
`else
      sub[(int'(cnt_q) * LANES + l) * 8 +: 8] = fwd_sbox(data_q[(int'(cnt_q) * LANES + l) * 8 +: 8]);
`endif
    end
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = BUSY;
        data_d  = in_data;
        cnt_d   = '0;
`ifdef INV_SBOX_EN
        mode_d  = inv_mode;
`endif
      end
      BUSY: begin
        data_d = sub;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          out_d   = sub;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign out_valid = state_q == DONE;
  assign out_data  = out_q;
endmodule

// File: tb/tb_sub_bytes_engine.sv
// tb_sub_bytes_engine: scoreboard bench for sub_bytes_engine with FIPS-197 vectors and a LANES sweep.
module tb_sub_bytes_engine;
  localparam logic [127:0] R1IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] R1OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] ALL63 = {16{8'h63}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         n_rst, in_valid, inv_mode, out_ready, in_ready, out_valid, busy;
  logic [127:0] in_data, out_data;

  sub_bytes_engine #(.LANES(4), .DATA_W(128)) dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .inv_mode(inv_mode), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  logic         sw_iv;
  logic [3:0]   sw_ir, sw_ov, sw_busy;
  logic [127:0] sw_od [4];

  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int L = g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 8 : 16;
    sub_bytes_engine #(.LANES(L), .DATA_W(128)) u (
      .clk(clk), .n_rst(n_rst), .in_valid(sw_iv), .in_ready(sw_ir[g]), .in_data(R1IN),
      .inv_mode(1'b0), .out_valid(sw_ov[g]), .out_ready(1'b1), .out_data(sw_od[g]),
      .busy(sw_busy[g])
    );
  end

  typedef struct {
    logic [127:0] d;
    int           acc;
    string        name;
  } exp_t;

  exp_t         sbq[$];
  int           tests = 0, fails = 0, cyc = 0, rel_cyc = -100;
  logic [127:0] cur = '0;
  bit           seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // monitor: pops the scoreboard on each new result, then watches it while held
  always @(negedge clk) begin
    exp_t e;
    if (n_rst) begin
      if (out_valid) begin
        if (!seen) begin
          if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_out_valid: got out_valid=1 with no block pending");
          end else begin
            e = sbq.pop_front();
            chk({e.name, "_data"}, out_data, e.d);
            chk({e.name, "_latency"}, 128'(cyc - e.acc), 128'(4));
            cur = e.d;
          end
          seen = 1'b1;
        end else begin
          chk("hold_data", out_data, cur);
          chk("hold_in_ready", 128'(in_ready), 128'(0));
        end
        if (out_ready) rel_cyc = cyc + 1;
      end else begin
        if (seen) chk("post_valid_hold", out_data, cur);
        seen = 1'b0;
      end
    end else seen = 1'b0;
  end

  task automatic send(input logic [127:0] d, input logic m, input bit keep,
                      input logic [127:0] exp, input string nm, output int acc);
    logic r;
    in_data  = d;
    inv_mode = m;
    in_valid = 1'b1;
    acc      = -1;
    for (int i = 0; i < 200 && acc < 0; i++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) acc = cyc;
    end
    if (acc < 0) begin
      tests++;
      fails++;
      $display("FAIL %s_accept_timeout: got no accept expected accept within 200 cycles", nm);
    end else sbq.push_back('{exp, acc, nm});
    if (!keep) begin
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      inv_mode = ~m;
    end
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (sbq.size() == 0 && !out_valid) break;
    end
    if (i == 100) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: got %0d pending expected 0", sbq.size());
    end
  endtask

  initial begin
    int a, b, acc;
    int lat [4];
    int lexp [4] = '{16, 8, 2, 1};
    n_rst = 1'b0; in_valid = 1'b0; in_data = '0; inv_mode = 1'b0; out_ready = 1'b1; sw_iv = 1'b0;
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data", out_data, '0);
    chk("rst_busy", 128'(busy), 128'(0));
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    chk("rst_in_ready", 128'(in_ready), 128'(1));

    send(R1IN, 1'b0, 1'b0, R1OUT, "round1", a);
    wait_idle();
    send('0, 1'b0, 1'b0, ALL63, "zeros", a);
    send({16{8'hff}}, 1'b0, 1'b0, {16{8'h16}}, "ones", a);
    send({120'h0, 8'h53}, 1'b0, 1'b0, {{15{8'h63}}, 8'hed}, "byte0_53", a);
`ifdef INV_SBOX_EN
    send(ALL63, 1'b1, 1'b0, '0, "inv_63", a);
    send(R1OUT, 1'b1, 1'b0, R1IN, "inv_round1", a);
`else
    send('0, 1'b1, 1'b0, ALL63, "mode_ignored", a);
`endif
    wait_idle();

    out_ready = 1'b0;
    fork
      begin
        send(R1IN, 1'b0, 1'b1, R1OUT, "bp_first", a);
        send('0, 1'b0, 1'b0, ALL63, "bp_second", b);
      end
      begin
        for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
        repeat (10) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    chk("bp_accept_cycle", 128'(b), 128'(rel_cyc + 1));
    wait_idle();

    send(R1IN, 1'b0, 1'b0, R1OUT, "rst_victim", a);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b0;
    sbq.delete();
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_out_data", out_data, '0);
    @(posedge clk);
    #1 n_rst = 1'b1;
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_stale", out_data, '0);
    send(R1IN, 1'b0, 1'b0, R1OUT, "after_rst", a);
    wait_idle();

    @(posedge clk);
    #1 sw_iv = 1'b1;
    @(posedge clk);
    #1 sw_iv = 1'b0;
    acc = cyc;
    lat = '{-1, -1, -1, -1};
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      for (int j = 0; j < 4; j++)
        if (sw_ov[j] && lat[j] < 0) begin
          lat[j] = cyc - acc;
          chk($sformatf("sweep%0d_data", j), sw_od[j], R1OUT);
        end
    end
    for (int j = 0; j < 4; j++) chk($sformatf("sweep%0d_latency", j), 128'(lat[j]), 128'(lexp[j]));

    chk("scoreboard_empty", 128'(sbq.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sub_bytes_engine.md
SUB_BYTES_ENGINE -- requirements
Module: sub_bytes_engine

Interface
REQ-001 The block SHALL have parameter: LANES, 4, number of bytes substituted per clock (legal values 1, 2, 4, 8, 16).
REQ-002 The block SHALL have parameter: DATA_W, 128, state width in bits (multiple of 8 × LANES; NBYTES = DATA_W/8).
REQ-003 The block SHALL reject any other LANES or DATA_W value at elaboration with a fatal error.
REQ-004 The block SHALL have port: clk  input  1  rising-edge system clock.
REQ-005 The block SHALL have port: n_rst  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port: in_valid  input  1  input block present.
REQ-007 The block SHALL have port: in_ready  output  1  engine can accept a block.
REQ-008 The block SHALL have port: in_data  input  DATA_W  state to substitute; byte k = bits [8k+7:8k].
REQ-009 The block SHALL have port: inv_mode  input  1  1 = inverse S-box; sampled with in_data.
REQ-010 The block SHALL have port: out_valid  output  1  result present.
REQ-011 The block SHALL have port: out_ready  input  1  downstream accepts the result.
REQ-012 The block SHALL have port: out_data  output  DATA_W  substituted state.
REQ-013 The block SHALL have port: busy  output  1  high in any state except IDLE.

Function
REQ-014 The block SHALL apply the FIPS-197 S-box (or inverse S-box) independently to every byte; byte position never changes.
REQ-015 The block SHALL implement FSM states IDLE, BUSY, DONE.
REQ-016 In IDLE, in_ready SHALL be 1; on in_valid=1, the block SHALL latch in_data and inv_mode, clear a byte-group counter, and go to BUSY.
REQ-017 In BUSY, each cycle the block SHALL substitute bytes [cnt × LANES, cnt × LANES + LANES − 1] in the internal register and increment cnt.
REQ-018 In BUSY, the block SHALL go to DONE on the cycle that processes the last group (cnt = NBYTES/LANES − 1).
REQ-019 Latency SHALL be NBYTES/LANES cycles from the accepting edge to out_valid=1 (default 4; LANES=16 gives 1).
REQ-020 In DONE, out_valid SHALL be 1 and out_data SHALL be stable; on out_ready=1, the block SHALL return to IDLE and deassert out_valid at that edge.
REQ-021 in_ready SHALL be 0 in BUSY and DONE; in_valid asserted in those states SHALL be ignored and not lost (the producer holds it).
REQ-022 A new block SHALL NOT be accepted in the same cycle DONE is released (no IDLE bypass); throughput = 1 block per NBYTES/LANES + 2 cycles.
REQ-023 out_data SHALL hold the last result after out_valid falls until the next DONE.
REQ-024 Changes to inv_mode or in_data after acceptance SHALL NOT affect the block in flight.
REQ-025 X on in_data SHALL be tolerated while in_valid=0.

Reset
REQ-026 n_rst=0 SHALL force, asynchronously: state IDLE, cnt 0, internal register 0, out_data 0, out_valid 0, busy 0, latched mode 0; in_ready SHALL be 1 once n_rst=1.
REQ-027 A reset asserted during BUSY or DONE SHALL discard the block in flight, with no out_valid pulse after release.

Configuration
REQ-028 With INV_SBOX_EN defined, inv_mode SHALL select the inverse table per block.
REQ-029 With INV_SBOX_EN undefined, the inverse table SHALL be absent, inv_mode SHALL be ignored, and the forward S-box SHALL always apply.

Verification
REQ-030 Reset check: n_rst pulsed low mid-BUSY -> out_valid=0, out_data=0, in_ready=1 after release; no stale result.
REQ-031 FIPS-197 round-1 vector, forward, LANES=4: in_data=0x193de3bea0f4e22b9ac68d2ae9f84808 -> out_data=0xd42711aee0bf98f1b8b45de51e415230, with out_valid exactly 4 cycles after acceptance.
REQ-032 Boundary bytes: in_data all 0x00 -> all 0x63; all 0xFF -> all 0x16; 0x53 in byte 0 -> 0xED in byte 0.
REQ-033 Inverse (INV_SBOX_EN defined): inv_mode=1, in_data all 0x63 -> all 0x00; the round-1 output vector above -> the original input.
REQ-034 Backpressure: out_ready held 0 for 10 cycles with in_valid=1 throughout -> out_data stable, in_ready=0, and exactly one new accept occurring 1 cycle after out_ready rises.
REQ-035 Parameter sweep: LANES ∈ {1, 2, 8, 16} with the REQ-031 vector -> identical out_data, and latency of 16, 8, 2 and 1 cycles respectively.
